// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core.
// Holds opcode/funct encodings, the FSM state encoding, the ALU operation
// codes and two small decode helpers used by the core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  // True when the opcode/funct pair belongs to the implemented subset.
  function automatic logic insn_supported(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // ALU operation for an R-type funct field.
  function automatic alu_op_t funct_alu_op(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// Combinational 32-bit ALU for the multi-cycle core.
// Ports:
//   a, b  : operands
//   op    : operation (add, sub, and, or, signed slt)
//   y     : result, 32-bit wrap-around arithmetic
//   zero  : y == 0, used for the beq compare
module mips_mc_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] y,
  output logic        zero
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, (a_s < b_s)};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core with a single shared instruction/data memory
// port (req/ready handshake, wait states allowed).
// Ports:
//   clk, reset              : rising-edge clock, synchronous active-low reset
//   mem_req/we/addr/wdata   : registered memory request, held while stalled
//   mem_rdata, mem_ready    : read data and transfer-complete strobe
//   halted                  : core stopped on an unsupported instruction
//   wb_valid/wb_reg/wb_data : register write performed at the coming edge
//   pc_out                  : current program counter
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          NUM_REGS = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [31:0]       ir;
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic [31:0]       regs [NUM_REGS];

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] br_off;
  logic [31:0] pc_ext;
  logic [31:0] jump_full;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_branch;

  logic        issue_fetch;
  logic        issue_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  alu_op_t     alu_op;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        wr_ok;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign br_off   = imm_sext << 2;

  // pc is already pc+4 by the time DECODE/EXEC run, so both targets use it directly.
  assign pc_plus4  = pc + ADDR_W'(4);
  assign pc_branch = pc + br_off[ADDR_W-1:0];
  assign pc_ext    = 32'(pc);
  assign jump_full = (pc_ext & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};

  assign halted = (state == ST_HALT);
  assign pc_out = pc;

  // Indices outside the implemented file, and r0, read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && int'(rs) < NUM_REGS) rs_val = regs[rs[IDX_W-1:0]];
    if (rt != 5'd0 && int'(rt) < NUM_REGS) rt_val = regs[rt[IDX_W-1:0]];
  end

  assign wr_ok = (wb_reg != 5'd0) && (int'(wb_reg) < NUM_REGS);

  mips_mc_alu u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Next-state, next-pc and request-issue decisions.
  // A fetch request is raised on the edge that enters FETCH so a zero-wait
  // fetch completes in the first FETCH cycle; only the cycle after reset
  // enters FETCH without a request, which FETCH then issues itself.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    issue_fetch = 1'b0;
    issue_data  = 1'b0;
    alu_a       = a_reg;
    alu_b       = imm_sext;
    alu_op      = ALU_ADD;
    case (state)
      ST_FETCH: begin
        if (!mem_req) begin
          issue_fetch = 1'b1;
        end else if (mem_ready) begin
          pc_next    = pc_plus4;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!insn_supported(opcode, funct)) begin
          state_next = ST_HALT;
        end else if (opcode == OP_J) begin
          pc_next     = jump_full[ADDR_W-1:0];
          state_next  = ST_FETCH;
          issue_fetch = 1'b1;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_b      = b_reg;
            alu_op     = funct_alu_op(funct);
            state_next = ST_WB;
          end
          OP_ADDI: state_next = ST_WB;
          OP_LW, OP_SW: begin
            issue_data = 1'b1;
            state_next = ST_MEM;
          end
          OP_BEQ: begin
            alu_b       = b_reg;
            alu_op      = ALU_SUB;
            if (alu_zero) pc_next = pc_branch;
            state_next  = ST_FETCH;
            issue_fetch = 1'b1;
          end
          default: state_next = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_req && mem_ready) begin
          if (opcode == OP_LW) begin
            state_next = ST_WB;
          end else begin
            state_next  = ST_FETCH;
            issue_fetch = 1'b1;
          end
        end
      end
      ST_WB: begin
        state_next  = ST_FETCH;
        issue_fetch = 1'b1;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= ADDR_W'(RESET_PC);
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      wb_valid <= 1'b0;

      // Memory port: a request is only ever replaced on its completing edge,
      // so the request signals stay frozen through wait states.
      if (issue_fetch) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= pc_next;
      end else if (issue_data) begin
        mem_req  <= 1'b1;
        mem_we   <= (opcode == OP_SW);
        mem_addr <= alu_y[ADDR_W-1:0] & ~ADDR_W'(3);
        if (opcode == OP_SW) mem_wdata <= b_reg;
      end else if (mem_req && mem_ready) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      case (state)
        // FETCH -> DECODE: latch the instruction
        ST_FETCH: if (mem_req && mem_ready) ir <= mem_rdata;
        // DECODE -> EXEC: register operands
        ST_DECODE: begin
          a_reg <= rs_val;
          b_reg <= rt_val;
        end
        // EXEC -> WB: ALU result staged for writeback
        ST_EXEC: begin
          if (opcode == OP_RTYPE || opcode == OP_ADDI) begin
            wb_valid <= 1'b1;
            wb_reg   <= (opcode == OP_RTYPE) ? rd : rt;
            wb_data  <= alu_y;
          end
        end
        // MEM -> WB: load data doubles as the MDR
        ST_MEM: begin
          if (mem_req && mem_ready && opcode == OP_LW) begin
            wb_valid <= 1'b1;
            wb_reg   <= rt;
            wb_data  <= mem_rdata;
          end
        end
        // WB -> FETCH: commit; r0 and out-of-range indices are not stored
        ST_WB: if (wr_ok) regs[wb_reg[IDX_W-1:0]] <= wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a default-parameter core with a
// wait-state memory model, plus a 12-bit / 8-register core with zero-wait
// memory.
module tb_mips_multicycle_core;

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter core
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted, wb_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data, pc_out;
  logic [4:0]  wb_reg;

  // ADDR_W=12, NUM_REGS=8 core
  logic        reset2;
  logic        mem_req2, mem_we2, mem_ready2, halted2, wb_valid2;
  logic [11:0] mem_addr2, pc_out2;
  logic [31:0] mem_wdata2, mem_rdata2, wb_data2;
  logic [4:0]  wb_reg2;

  mips_multicycle_core dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .pc_out(pc_out)
  );

  mips_multicycle_core #(.ADDR_W(12), .NUM_REGS(8), .RESET_PC(0)) dut2 (
    .clk(clk), .reset(reset2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .halted(halted2), .wb_valid(wb_valid2), .wb_reg(wb_reg2), .wb_data(wb_data2),
    .pc_out(pc_out2)
  );

  // Memory model: program words in mem[], the last store kept aside.
  logic [31:0] mem  [64];
  logic [31:0] mem2 [64];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        wr_seen = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  assign mem_ready  = mem_req && (wcnt == wait_n);
  assign mem_rdata  = (wr_seen && mem_addr == wr_addr) ? wr_data : mem[mem_addr[7:2]];
  assign mem_ready2 = mem_req2;
  assign mem_rdata2 = mem2[mem_addr2[7:2]];

  always @(posedge clk) begin
    if (!reset) wr_seen <= 1'b0;
    else if (mem_req && mem_ready && mem_we) begin
      wr_seen <= 1'b1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_j(input int t);
    return {6'b000010, t[25:0]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'hFC00_0000;
  endtask

  task automatic restart();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Wait (bounded) for a writeback pulse and check destination and data.
  task automatic wait_wb(input bit second, input string tag, input int r, input logic [31:0] d);
    int n;
    n = 0;
    while ((second ? wb_valid2 : wb_valid) !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(second ? wb_valid2 : wb_valid), 32'd1);
    chk({tag, "_reg"}, 32'(second ? wb_reg2 : wb_reg), 32'(r));
    chk({tag, "_data"}, second ? wb_data2 : wb_data, d);
    tick();
  endtask

  // Wait (bounded) for a fetch request at addr on the default core.
  task automatic wait_fetch(input string tag, input logic [31:0] addr);
    int n;
    n = 0;
    while (!(mem_req && mem_ready && !mem_we && mem_addr == addr) && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_fetch"}, 32'(mem_req && mem_ready && mem_addr == addr), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int waits;
    int req_seen;

    reset  = 1'b0;
    reset2 = 1'b0;
    for (int i = 0; i < 64; i++) mem2[i] = 32'h0000_0000;
    mem2[0] = enc_i(ADDI, 0, 9, 3);
    mem2[1] = enc_i(ADDI, 9, 2, 1);
    mem2[2] = enc_i(ADDI, 0, 7, 9);
    mem2[3] = enc_i(ADDI, 7, 3, 1);
    mem2[4] = enc_j((1 << 20) | 6);
    mem2[6] = enc_j(6);

    // ---- 1: reset state and back-to-back ALU writebacks
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 1, 5);
    mem[1] = enc_i(ADDI, 0, 2, 7);
    mem[2] = enc_r(1, 2, 3, F_ADD);
    mem[3] = enc_j(3);
    tick();
    tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbreg", 32'(wb_reg), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        chk("t1_first_req", 32'(mem_req), 32'd1);
        chk("t1_first_addr", mem_addr, 32'd0);
      end
      chk($sformatf("t1_wbv_c%0d", c), 32'(wb_valid), (c % 4 == 0) ? 32'd1 : 32'd0);
      if (c % 4 == 0) begin
        chk($sformatf("t1_wbreg_c%0d", c), 32'(wb_reg), 32'(c / 4));
        chk($sformatf("t1_wbdata_c%0d", c), wb_data, (c == 4) ? 32'd5 : (c == 8) ? 32'd7 : 32'd12);
      end
    end

    // ---- 2: store then load with 3 wait states on every access
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 3, 12);
    mem[1] = enc_j(4);
    mem[4] = enc_i(SW, 0, 3, 8);
    mem[5] = enc_i(LW, 0, 4, 8);
    mem[6] = enc_j(6);
    wait_n = 3;
    restart();
    wait_wb(0, "t2_addi", 3, 32'd12);
    n = 0;
    while (!(mem_req && mem_we) && n < 100) begin
      tick();
      n++;
    end
    chk("t2_sw_req", 32'(mem_req && mem_we), 32'd1);
    chk("t2_sw_addr", mem_addr, 32'd8);
    chk("t2_sw_wdata", mem_wdata, 32'd12);
    waits = 0;
    while (!mem_ready && waits < 10) begin
      tick();
      waits++;
      chk("t2_hold_req", 32'({mem_req, mem_we}), 32'd3);
      chk("t2_hold_addr", mem_addr, 32'd8);
      chk("t2_hold_wdata", mem_wdata, 32'd12);
    end
    chk("t2_wait_cycles", 32'(waits), 32'd3);
    tick();
    chk("t2_wr_seen", 32'(wr_seen), 32'd1);
    chk("t2_wr_addr", wr_addr, 32'd8);
    chk("t2_wr_data", wr_data, 32'd12);
    wait_wb(0, "t2_lw", 4, 32'd12);

    // ---- 3a: taken beq loops back to itself
    wait_n = 0;
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 1, 5);
    mem[1] = enc_i(ADDI, 0, 2, 7);
    mem[2] = enc_j(4);
    mem[4] = enc_i(BEQ, 1, 1, -1);
    restart();
    wait_wb(0, "t3_r1", 1, 32'd5);
    wait_wb(0, "t3_r2", 2, 32'd7);
    wait_fetch("t3a", 32'h10);
    tick();
    chk("t3a_pc_dec", pc_out, 32'h14);
    tick();
    chk("t3a_pc_exec", pc_out, 32'h14);
    chk("t3a_req_exec", 32'(mem_req), 32'd0);
    tick();
    chk("t3a_pc_taken", pc_out, 32'h10);
    chk("t3a_refetch_req", 32'(mem_req), 32'd1);
    chk("t3a_refetch_addr", mem_addr, 32'h10);

    // ---- 3b: beq not taken falls through
    mem[4] = enc_i(BEQ, 1, 2, 5);
    mem[5] = enc_j(5);
    restart();
    wait_fetch("t3b", 32'h10);
    tick();
    tick();
    tick();
    chk("t3b_pc", pc_out, 32'h14);
    chk("t3b_next_addr", mem_addr, 32'h14);

    // ---- 4: sub/slt/and/or and r0 behaviour
    clear_mem();
    mem[0]  = enc_i(ADDI, 0, 1, 5);
    mem[1]  = enc_i(ADDI, 0, 2, 7);
    mem[2]  = enc_r(1, 2, 4, F_SUB);
    mem[3]  = enc_r(2, 1, 5, F_SLT);
    mem[4]  = enc_r(1, 2, 7, F_SLT);
    mem[5]  = enc_r(1, 2, 0, F_ADD);
    mem[6]  = enc_r(0, 0, 6, F_ADD);
    mem[7]  = enc_r(1, 2, 8, F_AND);
    mem[8]  = enc_r(1, 2, 9, F_OR);
    mem[9]  = enc_i(ADDI, 0, 10, -3);
    mem[10] = enc_r(10, 1, 11, F_SLT);
    mem[11] = enc_j(11);
    restart();
    wait_wb(0, "t4_r1", 1, 32'd5);
    wait_wb(0, "t4_r2", 2, 32'd7);
    wait_wb(0, "t4_sub", 4, 32'hFFFF_FFFE);
    wait_wb(0, "t4_slt0", 5, 32'd0);
    wait_wb(0, "t4_slt1", 7, 32'd1);
    wait_wb(0, "t4_r0w", 0, 32'd12);
    wait_wb(0, "t4_r0rd", 6, 32'd0);
    wait_wb(0, "t4_and", 8, 32'd5);
    wait_wb(0, "t4_or", 9, 32'd7);
    wait_wb(0, "t4_neg", 10, 32'hFFFF_FFFD);
    wait_wb(0, "t4_sltneg", 11, 32'd1);

    // ---- 5: unsupported opcode halts until reset
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 1, 5);
    restart();
    wait_wb(0, "t5_r1", 1, 32'd5);
    n = 0;
    while (!halted && n < 20) begin
      tick();
      n++;
    end
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_pc", pc_out, 32'd8);
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req) req_seen++;
    end
    chk("t5_no_req", 32'(req_seen), 32'd0);
    chk("t5_sticky", 32'(halted), 32'd1);
    reset = 1'b0;
    tick();
    chk("t5_rst_halted", 32'(halted), 32'd0);
    chk("t5_rst_pc", pc_out, 32'd0);
    chk("t5_rst_req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    tick();
    chk("t5_resume_req", 32'(mem_req), 32'd1);
    chk("t5_resume_addr", mem_addr, 32'd0);
    wait_wb(0, "t5_again", 1, 32'd5);

    // ---- 6: reset during a stalled fetch
    clear_mem();
    mem[0] = enc_j(4);
    mem[4] = enc_j(4);
    restart();
    for (int i = 0; i < 6; i++) tick();
    wait_n = 100;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_stall_req", 32'(mem_req), 32'd1);
    chk("t6_stall_pc", pc_out, 32'h10);
    chk("t6_stall_addr", mem_addr, 32'h10);
    reset = 1'b0;
    tick();
    chk("t6_rst_req", 32'(mem_req), 32'd0);
    chk("t6_rst_pc", pc_out, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    reset = 1'b1;
    wait_n = 0;

    // ---- 7: ADDR_W=12, NUM_REGS=8
    reset2 = 1'b1;
    wait_wb(1, "t7_r9", 9, 32'd3);
    wait_wb(1, "t7_r9rd", 2, 32'd1);
    wait_wb(1, "t7_r7", 7, 32'd9);
    wait_wb(1, "t7_r7rd", 3, 32'd10);
    n = 0;
    while (!(mem_req2 && mem_addr2 == 12'h018) && n < 40) begin
      tick();
      n++;
    end
    chk("t7_jaddr", 32'(mem_addr2), 32'h018);
    chk("t7_jpc", 32'(pc_out2), 32'h018);
    for (int i = 0; i < 6; i++) tick();
    chk("t7_not_halted", 32'(halted2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
